rr_arbiter_ctrl: RTL

Round-robin arbiter that shares one downstream resource between N requesters, such as a priority-encoded datapath or bus port. It resolves requests through a rotating-priority encoder and holds a registered one-hot grant until the owner releases it. It optionally pre-empts an owner that holds the grant for MAX_HOLD cycles while other requesters wait. It sits between the requesting blocks and the shared resource; all outputs are registered.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_arbiter_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
//   arb_state_e    : controller state (IDLE, GRANT)
//   ARB_N_DEF      : default number of requesters
//   ARB_MAX_HOLD_DEF : default hold limit before forced release
//   onehot_to_idx  : binary index of the (single) set bit of a one-hot vector
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

    // Returns the index of the lowest set bit; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   ptr     : highest-priority position this round
//   any     : at least one request is set
//   win_idx : first set bit of req scanning ptr, ptr+1, ... wrapping N-1 -> 0
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Doubling the vector turns the rotate-right into a plain part-select.
        dbl = {req, req};
        rot = dbl[ptr +: N];
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = IDX_W'(j);
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        win_idx = sum[IDX_W-1:0];
        any     = |req;
    end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with registered one-hot grant and optional pre-emption.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : level requests, held high while the resource is needed
//   gnt        : registered one-hot grant, zero when idle
//   gnt_idx    : index of the current / last owner (not cleared on release)
//   gnt_valid  : registered copy of |gnt
//   preempt    : one-cycle pulse after a forced release
//   dbg_state  : current controller state (arb_state_e encoding)
// There is no handshake: an owner keeps gnt while its req stays high and
// releases it by dropping req; the resource then idles for one cycle.
module rr_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt,
    output logic [0:0]       dbg_state
);

    // Last hold_cnt value of a full MAX_HOLD-cycle tenure.
    localparam logic [CNT_W-1:0] HOLD_LIM =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   ptr_nxt;
    logic [IDX_W-1:0] owner;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .win_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        owner     = IDX_W'(onehot_to_idx(32'(gnt_q)));
        ptr_nxt   = {1'b0, pick_idx} + 1'b1;
        if (ptr_nxt >= (IDX_W + 1)'(N)) ptr_nxt = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = N'(1) << pick_idx;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                    ptr_d   = ptr_nxt[IDX_W-1:0];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_q >= HOLD_LIM) &&
                             ((req & ~gnt_q) != '0)) begin
                    // '>=' lets a saturated, uncontended owner be pre-empted
                    // as soon as a competitor shows up.
                    gnt_d     = '0;
                    preempt_d = 1'b1;
                    state_d   = IDLE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = |gnt_d;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;
    assign dbg_state = state_q;

endmodule
